// File: rtl/pin_array_deser.sv
// Serial-bit to WIDTH-bit word deserializer with a DEPTH-entry output FIFO (valid/ready).
// Optional macro PIN_ARRAY_DESER_PARITY_EN appends an even-parity bit per word and adds parity_err.
module pin_array_deser #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     vin_valid,
  input  logic                     vin,
  output logic [WIDTH-1:0]         vout,
  output logic                     vout_valid,
  input  logic                     vout_ready,
  output logic [$clog2(DEPTH):0]   level,
`ifdef PIN_ARRAY_DESER_PARITY_EN
  output logic                     parity_err,
`endif
  output logic                     overflow
);

`ifdef PIN_ARRAY_DESER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS);
  localparam int IW = $clog2(WIDTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_mem [0:(2**AW)-1];
  logic [AW-1:0]    r_wr, r_rd;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_vout;
  logic             r_vld;
  logic             r_ovf;

  logic             w_acc, w_last, w_data, w_pop, w_full, w_wr;
  logic [IW-1:0]    w_idx;
  logic [WIDTH-1:0] w_word, w_next_head;
  logic [LW-1:0]    w_level_nxt;

  assign w_acc  = en & vin_valid;
  assign w_last = w_acc && (r_cnt == CW'(NBITS-1));
  // The parity slot (cnt == WIDTH) carries no data bit.
  assign w_data = w_acc && (int'(r_cnt) < WIDTH);
  assign w_idx  = (MSB_FIRST != 0) ? (IW'(WIDTH-1) - IW'(r_cnt)) : IW'(r_cnt);

  always_comb begin
    w_word = r_shift;
    if (w_data) w_word[w_idx] = vin;
  end

  assign w_pop       = r_vld & vout_ready;
  assign w_full      = (r_level == LW'(DEPTH));
  assign w_wr        = w_last & (~w_full | w_pop);
  assign w_next_head = r_mem[r_rd + AW'(1)];

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr && !w_pop)      w_level_nxt = r_level + LW'(1);
    else if (!w_wr && w_pop) w_level_nxt = r_level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_wr && !clear) r_mem[r_wr] <= w_word;
  end

`ifdef PIN_ARRAY_DESER_PARITY_EN
  logic r_perr;
  assign parity_err = r_perr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_perr <= 1'b0;
    else if (clear)                     r_perr <= 1'b0;
    else if (w_last && ((^r_shift) != vin)) r_perr <= 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_vout  <= '0;
      r_vld   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_vout  <= '0;
      r_vld   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_acc) begin
        if (w_last) begin
          r_cnt   <= '0;
          r_shift <= '0;
        end else begin
          r_cnt   <= r_cnt + CW'(1);
          r_shift <= w_word;
        end
      end
      if (w_last && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_wr)  r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_level <= w_level_nxt;
      // vout is a registered copy of the head so it holds the last popped word when empty.
      if (w_pop) begin
        if (r_level > LW'(1)) r_vout <= w_next_head;
        else if (w_wr)        r_vout <= w_word;
        else                  r_vld  <= 1'b0;
      end else if (w_wr && !r_vld) begin
        r_vout <= w_word;
        r_vld  <= 1'b1;
      end
    end
  end

  assign vout       = r_vout;
  assign vout_valid = r_vld;
  assign level      = r_level;
  assign overflow   = r_ovf;

endmodule
